// File: rtl/serial_frame_tx_pkg.sv
// Shared frame-format constants and FSM state encoding for the serial port-demux link.
// The receiver side imports the same package so both ends agree on field widths.
package serial_frame_tx_pkg;

    localparam int LEN_W      = 4;
    localparam int PORT_W     = 2;
    localparam int DATA_W     = (1 << LEN_W) - 1;
    localparam int PORT_IDX_W = $clog2(PORT_W);
    localparam int LEN_IDX_W  = $clog2(LEN_W);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        STB  = 3'd1,
        PORT = 3'd2,
        LEN  = 3'd3,
        DATA = 3'd4,
        FIN  = 3'd5
    } txState_e;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Parallel request side and serial/status side of the frame transmitter.
interface serial_frame_tx_if;
    import serial_frame_tx_pkg::*;

    logic              Start;
    logic [PORT_W-1:0] Port;
    logic [LEN_W-1:0]  Len;
    logic [DATA_W-1:0] Data;
    logic              SerOut;
    logic              Busy;
    logic              Done;

    modport master (output Start, Port, Len, Data, input SerOut, Busy, Done);
    modport slave  (input Start, Port, Len, Data, output SerOut, Busy, Done);

endinterface

// File: rtl/serial_frame_tx_counter.sv
// Loadable down-counter indexing the current bit within the port, length and data fields.
module frame_bit_counter
    import serial_frame_tx_pkg::*;
#(
    parameter int W = LEN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] loadVal_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Stops at zero; the FSM reloads it before the next field begins.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = loadVal_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, port, length, then Len data bits MSB first.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clkEn,
    serial_frame_tx_if.slave  bus
);

    txState_e          state_q, state_d;
    logic [PORT_W-1:0] port_q, port_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              cntLoad;
    logic [LEN_W-1:0]  cntLoadVal;
    logic              cntEn;
    logic [LEN_W-1:0]  cnt;
    logic              cntZero;

    frame_bit_counter #(.W(LEN_W)) u_counter (
        .clk       (clk),
        .rst       (rst),
        .load_i    (cntLoad),
        .loadVal_i (cntLoadVal),
        .en_i      (cntEn),
        .cnt_o     (cnt),
        .zero_o    (cntZero)
    );

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        len_d      = len_q;
        data_d     = data_q;
        cntLoad    = 1'b0;
        cntLoadVal = '0;
        cntEn      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    port_d  = bus.Port;
                    len_d   = bus.Len;
                    data_d  = bus.Data;
                    state_d = STB;
                end
            end
            STB: begin
                if (clkEn) begin
                    state_d    = PORT;
                    cntLoad    = 1'b1;
                    cntLoadVal = LEN_W'(PORT_W - 1);
                end
            end
            PORT: begin
                if (clkEn) begin
                    if (cntZero) begin
                        state_d    = LEN;
                        cntLoad    = 1'b1;
                        cntLoadVal = LEN_W'(LEN_W - 1);
                    end else begin
                        cntEn = 1'b1;
                    end
                end
            end
            LEN: begin
                if (clkEn) begin
                    if (!cntZero) begin
                        cntEn = 1'b1;
                    end else if (len_q == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d    = DATA;
                        cntLoad    = 1'b1;
                        cntLoadVal = len_q - 1'b1;
                    end
                end
            end
            DATA: begin
                if (clkEn) begin
                    if (cntZero) begin
                        state_d = FIN;
                    end else begin
                        cntEn = 1'b1;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            port_q  <= '0;
            len_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            len_q   <= len_d;
            data_q  <= data_d;
        end
    end

    // Line level is a pure decode of registered state, captured fields and counter.
    always_comb begin
        bus.SerOut = 1'b1;
        case (state_q)
            STB:     bus.SerOut = 1'b0;
            PORT:    bus.SerOut = port_q[cnt[PORT_IDX_W-1:0]];
            LEN:     bus.SerOut = len_q[cnt[LEN_IDX_W-1:0]];
            DATA:    bus.SerOut = data_q[cnt];
            default: bus.SerOut = 1'b1;
        endcase
    end

    assign bus.Busy = (state_q == STB) || (state_q == PORT) ||
                      (state_q == LEN) || (state_q == DATA);
    assign bus.Done = (state_q == FIN);

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx with hand-computed serial bit sequences.
module tb_serial_frame_tx;
    import serial_frame_tx_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic clkEn;
    int   checks = 0;
    int   errors = 0;

    serial_frame_tx_if bus();

    serial_frame_tx dut (
        .clk   (clk),
        .rst   (rst),
        .clkEn (clkEn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle; afterwards the DUT sits in its start-bit state.
    task automatic applyStimulus(input logic [PORT_W-1:0] p, input logic [LEN_W-1:0] l,
                                 input logic [DATA_W-1:0] d);
        bus.Port  = p;
        bus.Len   = l;
        bus.Data  = d;
        bus.Start = 1'b1;
        clkEn     = 1'b0;
        tick();
        bus.Start = 1'b0;
    endtask

    // Walks the frame bit by bit, holding each for `period` cycles, then checks the Done cycle.
    task automatic runFrame(input string tag, input logic [21:0] expBits, input int nBits,
                            input int period, input int pokeAt, input bit pokeFin);
        for (int i = 0; i < nBits; i++) begin
            for (int k = 0; k < period; k++) begin
                checkOutput({tag, "_ser"},  bus.SerOut, expBits[nBits-1-i]);
                checkOutput({tag, "_busy"}, bus.Busy, 1'b1);
                checkOutput({tag, "_done"}, bus.Done, 1'b0);
                if (i == pokeAt && k == 0) begin
                    bus.Start = 1'b1;
                    bus.Port  = '0;
                    bus.Len   = 4'd1;
                    bus.Data  = '0;
                end else begin
                    bus.Start = 1'b0;
                end
                clkEn = (k == period - 1);
                tick();
            end
        end
        clkEn     = 1'b0;
        bus.Start = pokeFin;
        checkOutput({tag, "_finDone"}, bus.Done, 1'b1);
        checkOutput({tag, "_finBusy"}, bus.Busy, 1'b0);
        checkOutput({tag, "_finSer"},  bus.SerOut, 1'b1);
        tick();
        bus.Start = 1'b0;
        checkOutput({tag, "_idleDone"}, bus.Done, 1'b0);
        checkOutput({tag, "_idleBusy"}, bus.Busy, 1'b0);
        checkOutput({tag, "_idleSer"},  bus.SerOut, 1'b1);
    endtask

    initial begin
        // Reset held with Start asserted must not launch a frame.
        rst       = 1'b0;
        clkEn     = 1'b1;
        bus.Start = 1'b1;
        bus.Port  = 2'd3;
        bus.Len   = 4'd8;
        bus.Data  = 15'h00B3;
        for (int c = 0; c < 2; c++) begin
            tick();
            checkOutput("rst_ser",  bus.SerOut, 1'b1);
            checkOutput("rst_busy", bus.Busy, 1'b0);
            checkOutput("rst_done", bus.Done, 1'b0);
        end
        rst = 1'b1;
        tick();
        bus.Start = 1'b0;
        runFrame("basic", 22'b011100010110011, 15, 1, -1, 1'b0);

        applyStimulus(2'd1, 4'd0, 15'h7FFF);
        runFrame("zero", 22'b0010000, 7, 1, -1, 1'b0);

        applyStimulus(2'd2, 4'd15, 15'h7FFF);
        runFrame("throttle", 22'b0101111111111111111111, 22, 4, -1, 1'b0);

        // Start pulsed mid-frame with new fields and again during the Done cycle.
        applyStimulus(2'd3, 4'd8, 15'h00B3);
        runFrame("ignore", 22'b011100010110011, 15, 1, 9, 1'b1);
        for (int c = 0; c < 3; c++) begin
            checkOutput("ignore_quietBusy", bus.Busy, 1'b0);
            checkOutput("ignore_quietSer",  bus.SerOut, 1'b1);
            tick();
        end

        // Abort inside the data field: after 10 enables the line carries data bit 4 (=1).
        applyStimulus(2'd3, 4'd8, 15'h00B3);
        clkEn = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        checkOutput("abort_preSer",  bus.SerOut, 1'b1);
        checkOutput("abort_preBusy", bus.Busy, 1'b1);
        rst = 1'b0;
        tick();
        checkOutput("abort_ser",  bus.SerOut, 1'b1);
        checkOutput("abort_busy", bus.Busy, 1'b0);
        checkOutput("abort_done", bus.Done, 1'b0);
        rst   = 1'b1;
        clkEn = 1'b0;
        tick();
        checkOutput("abort_postDone", bus.Done, 1'b0);
        checkOutput("abort_postBusy", bus.Busy, 1'b0);

        applyStimulus(2'd2, 4'd3, 15'h0005);
        runFrame("fresh", 22'b0100011101, 10, 1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
